// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the memory request path.
// The memory block imports the same defaults so both sides agree on widths.
package mem_pkg;

  localparam int MEM_W   = 4;
  localparam int MEM_D   = 16;
  localparam int MEM_TMO = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO. DEPTH must be a power of two so the pointers
// wrap naturally. The head entry is shown combinationally on dout_o.
module cmd_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DW-1:0]            din_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Guards make an illegal push/pop a no-op instead of corrupting the count.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request-side controller for the 16x4 memory: queues commands, issues them
// one at a time, waits for a (possibly asynchronous) ready, and returns a
// one-cycle response. A watchdog turns a missing ready into an error response.
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int W        = MEM_W,
  parameter int D        = MEM_D,
  parameter int N        = $clog2(D),
  parameter int CQ_DEPTH = 4,
  parameter int TMO      = MEM_TMO
) (
  input  logic         clk,
  input  logic         res,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_wr_rd,
  input  logic [N-1:0] cmd_addr,
  input  logic [W-1:0] cmd_wdata,
  output logic         mem_valid,
  output logic         mem_wr_rd,
  output logic [N-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic         rsp_valid,
  output logic         rsp_wr,
  output logic [N-1:0] rsp_addr,
  output logic [W-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         busy
);

  localparam int CMD_W = 1 + N + W;
  localparam int TW    = $clog2(TMO + 1);

  logic                      fifo_full, fifo_empty;
  logic [$clog2(CQ_DEPTH):0] fifo_count;
  logic [CMD_W-1:0]          fifo_dout;
  logic                      pop;

  state_e                    state_q;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      tmo_hit;

  logic                      rdy_meta_q, rdy_sync_q, rdy_prev_q, rdy_rise;

  logic                      mem_valid_q, mem_wr_rd_q;
  logic [N-1:0]              mem_addr_q;
  logic [W-1:0]              mem_wdata_q;
  logic                      rsp_valid_q, rsp_wr_q, rsp_err_q;
  logic [N-1:0]              rsp_addr_q;
  logic [W-1:0]              rsp_rdata_q;

  // Held low during reset so nothing is accepted while state is being cleared.
  assign cmd_ready = !res && !fifo_full;
  assign pop       = (state_q == IDLE) && !fifo_empty;
  assign busy      = (fifo_count != '0) || (state_q != IDLE);

  cmd_fifo #(
    .DW    (CMD_W),
    .DEPTH (CQ_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (res),
    .push_i  (cmd_valid && cmd_ready),
    .din_i   ({cmd_wr_rd, cmd_addr, cmd_wdata}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ready may come from another clock domain: two flops, then edge detect.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rdy_meta_q <= 1'b0;
      rdy_sync_q <= 1'b0;
      rdy_prev_q <= 1'b0;
    end else begin
      rdy_meta_q <= mem_ready;
      rdy_sync_q <= rdy_meta_q;
      rdy_prev_q <= rdy_sync_q;
    end
  end

  assign rdy_rise = rdy_sync_q && !rdy_prev_q;
  assign timer_d  = timer_q + 1'b1;
  assign tmo_hit  = (timer_q == TW'(TMO - 1));

  // Issue / wait / respond sequencer; every memory and response output is a flop.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            {mem_wr_rd_q, mem_addr_q, mem_wdata_q} <= fifo_dout;
            mem_valid_q <= 1'b1;
            timer_q     <= '0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          timer_q <= timer_d;
          // A ready edge on the last allowed cycle still counts as success.
          if (rdy_rise) begin
            mem_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_wr_q    <= mem_wr_rd_q;
            rsp_addr_q  <= mem_addr_q;
            rsp_rdata_q <= mem_wr_rd_q ? '0 : mem_rdata;
            rsp_err_q   <= 1'b0;
            state_q     <= RESP;
          end else if (tmo_hit) begin
            mem_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_wr_q    <= mem_wr_rd_q;
            rsp_addr_q  <= mem_addr_q;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          // One-cycle pulse; also gives mem_valid two low cycles between accesses.
          rsp_valid_q <= 1'b0;
          rsp_wr_q    <= 1'b0;
          rsp_addr_q  <= '0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_wr_rd = mem_wr_rd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: behavioural memory with configurable latency and a
// queue-based reference of expected responses in command order.
module tb_mem_req_ctrl;

  localparam int W   = 4;
  localparam int D   = 16;
  localparam int N   = 4;
  localparam int CQ  = 4;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         res;
  logic         cmd_valid, cmd_ready, cmd_wr_rd;
  logic [N-1:0] cmd_addr;
  logic [W-1:0] cmd_wdata;
  logic         mem_valid, mem_wr_rd, mem_ready;
  logic [N-1:0] mem_addr;
  logic [W-1:0] mem_wdata, mem_rdata;
  logic         rsp_valid, rsp_wr, rsp_err, busy;
  logic [N-1:0] rsp_addr;
  logic [W-1:0] rsp_rdata;

  always #5 clk = ~clk;

  mem_req_ctrl #(.W(W), .D(D), .N(N), .CQ_DEPTH(CQ), .TMO(TMO)) dut (
    .clk(clk), .res(res),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_addr(rsp_addr),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    bit         wr;
    bit [N-1:0] addr;
    bit [W-1:0] wdata;
    bit         err;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mem_arr [D];
  logic [W-1:0] ref_mem [D];
  logic [W-1:0] last_rdata;
  int total = 0, bad = 0;
  int lat = 0;
  bit hold = 0, never = 0;
  int issue_cnt = 0, rsp_cnt = 0, low_run = 100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: answers after 'lat' wait cycles, holds ready until valid drops.
  initial begin : mem_model
    int   cyc;
    logic prev_mv;
    cyc = 0; prev_mv = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (res) begin
        mem_ready = 1'b0; cyc = 0; prev_mv = 1'b0; low_run = 100;
      end else begin
        if (mem_valid && !prev_mv) begin
          issue_cnt++;
          chk("mem_valid_gap", low_run >= 2, 1);
        end
        low_run = mem_valid ? 0 : low_run + 1;
        prev_mv = mem_valid;
        if (mem_valid && !mem_ready) begin
          cyc++;
          if (!hold && !never && cyc > lat) begin
            if (mem_wr_rd) mem_arr[mem_addr] = mem_wdata;
            else           mem_rdata = mem_arr[mem_addr];
            mem_ready = 1'b1;
          end
        end else if (!mem_valid) begin
          mem_ready = 1'b0; cyc = 0;
        end
      end
    end
  end

  // Response checker: responses must arrive in push order with model data.
  initial begin : rsp_mon
    exp_t         e;
    logic [W-1:0] er;
    forever begin
      @(negedge clk);
      if (!res && rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e  = exp_q.pop_front();
          er = (e.wr || e.err) ? '0 : ref_mem[e.addr];
          chk("rsp_wr", rsp_wr, e.wr);
          chk("rsp_addr", rsp_addr, e.addr);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_rdata", rsp_rdata, er);
          if (e.wr && !e.err) ref_mem[e.addr] = e.wdata;
          last_rdata = rsp_rdata;
          rsp_cnt++;
        end
      end
    end
  end

  // Offer one command; ready seen at the negedge is what the next edge samples.
  task automatic push(input bit wr, input logic [N-1:0] a, input logic [W-1:0] d);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr_rd = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("push_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.wr = wr; e.addr = a; e.wdata = d;
      // Ready seen two sync cycles after it rises must land by timer TMO-1.
      e.err = never || (lat > TMO - 3);
      exp_q.push_back(e);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    int base, n, hi;
    cmd_valid = 1'b0; cmd_wr_rd = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    res = 1'b1;
    for (int i = 0; i < D; i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    res = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // 1: write then read the same address
    base = issue_cnt;
    push(1'b1, 4'd3, 4'hA);
    push(1'b0, 4'd3, 4'h0);
    drain();
    chk("t1_issues", issue_cnt - base, 2);
    chk("t1_rdata", last_rdata, 4'hA);

    // 2: fill the queue behind a stalled access
    lat = 0; hold = 1'b1; base = rsp_cnt;
    for (int i = 0; i < 5; i++) push(1'($urandom % 2), 4'($urandom), 4'($urandom));
    @(negedge clk);
    chk("t2_full_ready", cmd_ready, 0);
    chk("t2_busy", busy, 1);
    cmd_valid = 1'b1; cmd_wr_rd = 1'b1; cmd_addr = 4'd15; cmd_wdata = 4'hF;
    @(posedge clk);
    #1;
    chk("t2_sixth_refused", cmd_ready, 0);
    cmd_valid = 1'b0;
    hold = 1'b0;
    drain();
    chk("t2_rsp_count", rsp_cnt - base, 5);

    // 3: timeout, then normal service resumes
    never = 1'b1;
    push(1'b0, 4'($urandom), 4'h0);
    n = 0;
    while (!mem_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    hi = 0;
    while (mem_valid && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    chk("t3_valid_cycles", hi, TMO);
    drain();
    never = 1'b0;
    push(1'b1, 4'd5, 4'h6);
    push(1'b0, 4'd5, 4'h0);
    drain();
    chk("t3_recover_rdata", last_rdata, 4'h6);

    // 4: back-to-back commands, push coinciding with pop, pointer wrap
    base = rsp_cnt;
    for (int i = 0; i < 10; i++) begin
      lat = $urandom_range(0, 4);
      push(1'($urandom % 2), 4'(i), 4'($urandom));
    end
    drain();
    chk("t4_rsp_count", rsp_cnt - base, 10);

    // Random traffic with gaps and varying latency
    base = rsp_cnt;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      lat = $urandom_range(0, 4);
      push(1'($urandom % 2), 4'($urandom), 4'($urandom));
    end
    drain();
    chk("rand_rsp_count", rsp_cnt - base, 24);

    // 5: reset while waiting with two commands queued
    lat = 0;
    push(1'b1, 4'd3, 4'hA);
    drain();
    hold = 1'b1;
    push(1'b1, 4'd3, 4'h5);
    push(1'b1, 4'd3, 4'h6);
    push(1'b0, 4'd3, 4'h0);
    @(negedge clk);
    res = 1'b1;
    #1;
    chk("t5_mem_valid", mem_valid, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    hold = 1'b0;
    repeat (2) @(negedge clk);
    res = 1'b0;
    base = rsp_cnt;
    repeat (30) @(negedge clk);
    chk("t5_no_stale", rsp_cnt - base, 0);
    push(1'b0, 4'd3, 4'h0);
    drain();
    chk("t5_read_back", last_rdata, 4'hA);

    // 6: ready edge lands on the final timer cycle
    lat = TMO - 3;
    push(1'b0, 4'd3, 4'h0);
    push(1'b1, 4'd7, 4'h9);
    push(1'b0, 4'd7, 4'h0);
    drain();
    chk("t6_race_rdata", last_rdata, 4'h9);
    lat = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request-side controller sitting directly upstream of the 16x4 memory block.
- Buffers incoming read/write commands in a small command FIFO and issues them one at a time on the memory's valid/wr_rd/addr/wdata interface.
- Waits for the memory's ready, captures rdata on reads, and returns a one-cycle response pulse to the requester.
- A watchdog aborts any access the memory never acknowledges.

Parameters:
- W, 4, data width; must match memory w.
- D, 16, memory depth; must match memory d.
- N, $clog2(D), address width.
- CQ_DEPTH, 4, command FIFO depth; power of 2, at least 2.
- TMO, 8, WAIT-state cycles before timeout; at least 2.

Ports:
- clk  in  1  clock; all state on rising edge.
- res  in  1  asynchronous active-high reset.
- cmd_valid  in  1  requester offers a command.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_wr_rd  in  1  1=write, 0=read.
- cmd_addr  in  N  command address.
- cmd_wdata  in  W  write data; ignored for reads.
- mem_valid  out  1  access request to memory.
- mem_wr_rd  out  1  to memory wr_rd.
- mem_addr  out  N  to memory addr.
- mem_wdata  out  W  to memory wdata.
- mem_rdata  in  W  from memory rdata.
- mem_ready  in  1  from memory ready; may be asynchronous to clk.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_wr  out  1  completed command was a write.
- rsp_addr  out  N  address of completed command.
- rsp_rdata  out  W  read data; 0 for writes and errors.
- rsp_err  out  1  completion was a timeout.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (async, res=1):
  - FIFO pointers and count cleared.
  - FSM returns to IDLE.
  - All registered outputs are 0, including mem_valid, mem_wr_rd, mem_addr, mem_wdata and all rsp_*.
  - cmd_ready reads 0 while res=1, and 1 after release.
  - Reset asserted mid-access drops mem_valid immediately and discards the in-flight command and all queued commands; no response is produced for them.
- Command FIFO:
  - A push occurs when cmd_valid && cmd_ready at a clock edge.
  - A pop occurs when the FSM leaves IDLE.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - Push while full is not possible because cmd_ready=0.
  - Read and write pointers wrap modulo CQ_DEPTH.
  - Count is $clog2(CQ_DEPTH)+1 bits wide.
- mem_ready synchronisation:
  - Two-flop synchroniser, then a rising-edge detect (rdy_rise).
  - The memory must hold ready high for at least one clk period.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if FIFO is non-empty, pop the head and register it onto mem_wr_rd, mem_addr and mem_wdata. Set mem_valid<=1, clear the timer, go to WAIT. Otherwise stay in IDLE.
  - WAIT: mem_valid and the mem_* outputs are held stable and the timer increments each cycle.
    - On rdy_rise: mem_valid<=0. For reads, rsp_rdata<=mem_rdata; for writes, rsp_rdata<=0. rsp_err<=0. Go to RESP.
    - Else if timer==TMO-1: mem_valid<=0, rsp_err<=1, rsp_rdata<=0. Go to RESP.
    - If rdy_rise and timeout occur in the same cycle, rdy_rise wins and the access completes successfully.
  - RESP: rsp_valid=1 for exactly one cycle, with rsp_wr and rsp_addr from the issued command. Always go to IDLE.
    - This guarantees mem_valid is low for at least two cycles between accesses.
- Latency:
  - A command pushed into an empty FIFO at edge k gives mem_valid=1 after edge k+1.
  - If ready rises in WAIT cycle j, the synchroniser adds 2 cycles before rdy_rise.
  - rsp_valid is asserted the cycle after rdy_rise is seen.
- Responses carry no backpressure. Commands complete strictly in FIFO order.
- Timer width is $clog2(TMO+1).
- busy is combinational from count and state.

Decomposition:
- Shared package mem_pkg holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - default W, D and TMO constants, shared with the memory block so the widths agree.
- One natural sub-module: cmd_fifo, the parameterised synchronous FIFO storing {wr_rd, addr, wdata} and providing full, empty and count.
- The synchroniser and edge detect stay inline.

Test Plan:
1. Write then read: push (wr,addr=3,wdata=4'hA), then (rd,addr=3).
   - Required: mem_valid pulses twice in order.
   - First rsp: rsp_wr=1, rsp_addr=3, rsp_err=0.
   - Second rsp: rsp_wr=0, rsp_rdata=4'hA, rsp_addr=3.
2. Fill and backpressure: hold the memory model's ready low and push 5 commands with CQ_DEPTH=4.
   - Required: 1 command in flight plus 4 queued.
   - cmd_ready=0 while 4 are queued; the 6th push attempt is not accepted.
   - After ready resumes, all 5 complete in order.
3. Timeout: the memory model never asserts ready, TMO=8.
   - Required: mem_valid high exactly 8 cycles.
   - Then rsp_valid=1 with rsp_err=1 and rsp_rdata=0; the FSM then serves the next command normally.
4. Simultaneous push/pop: push a new command in the same edge that IDLE pops the last queued entry.
   - Required: count stays 1 and the new command issues next.
   - Pointer wrap is exercised over 10 back-to-back commands with addresses 0..9.
5. Reset mid-access: assert res while in WAIT with 2 commands queued.
   - Required: mem_valid=0 and rsp_valid=0 immediately; busy=0.
   - After release, no stale response appears and a new read of addr=3 returns 4'hA.
6. Ready/timeout race: the memory model asserts ready so that rdy_rise lands on the timer==TMO-1 cycle.
   - Required: rsp_err=0 and valid rsp_rdata.
